// File: rtl/approx_stats_pkg.sv
// Shared constants and state encoding for the approximate-multiplier error statistics block.
package approx_stats_pkg;

    localparam int DEF_CNT_W    = 17;
    localparam int DEF_SUM_W    = 33;
    localparam int DRAIN_CYCLES = 2;
    localparam int SQ_W         = 48;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

endpackage

// File: rtl/err_metric_unit.sv
// Two-stage error datapath: S1 registers operands and the exact product,
// S2 registers the signed difference (approx - exact) and its magnitude.
module err_metric_unit
    import approx_stats_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic [15:0] approx,
    output logic        vld_p2,
    output logic [16:0] diff_p2,
    output logic [15:0] ed_p2,
    output logic [7:0]  a_p2,
    output logic [7:0]  b_p2
);

    logic        vld_p1;
    logic [7:0]  a_p1;
    logic [7:0]  b_p1;
    logic [15:0] approx_p1;
    logic [15:0] exact_p1;
    logic signed [16:0] diff_c;

    // |d| always fits 16 bits because both operands are 16-bit unsigned.
    function automatic logic [15:0] abs_ed(input logic signed [16:0] d);
        logic signed [16:0] n;
        n = -d;
        abs_ed = d[16] ? n[15:0] : d[15:0];
    endfunction

    // S1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_p1 <= 1'b0;
        else        vld_p1 <= valid;
    end

    always_ff @(posedge clk) begin
        a_p1      <= a;
        b_p1      <= b;
        approx_p1 <= approx;
        exact_p1  <= {8'b0, a} * {8'b0, b};
    end

    assign diff_c = $signed({1'b0, approx_p1}) - $signed({1'b0, exact_p1});

    // S2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_p2 <= 1'b0;
        else        vld_p2 <= vld_p1;
    end

    always_ff @(posedge clk) begin
        diff_p2 <= diff_c;
        ed_p2   <= abs_ed(diff_c);
        a_p2    <= a_p1;
        b_p2    <= b_p1;
    end

endmodule

// File: rtl/approx_err_stats.sv
// Error-statistics accumulator for the 8x8 approximate multipliers.
// Optional sum of squared ED output enabled by macro APPROX_ERR_SQ_EN.
module approx_err_stats
    import approx_stats_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int SUM_W = DEF_SUM_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    input  logic [15:0]      prod_approx,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [SUM_W-1:0] ed_sum,
    output logic [SUM_W:0]   err_sum,
    output logic [15:0]      max_ed,
    output logic [7:0]       max_a,
    output logic [7:0]       max_b,
    output logic             cnt_ovf
`ifdef APPROX_ERR_SQ_EN
    ,
    output logic [SQ_W-1:0]  sq_sum
`endif
);

    state_t      state_q;
    state_t      state_d;
    logic [1:0]  drain_cnt;
    logic        accept;
    logic        clear;
    logic        vld_p2;
    logic [16:0] diff_p2;
    logic [15:0] ed_p2;
    logic [7:0]  a_p2;
    logic [7:0]  b_p2;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign in_ready = (state_q == RUN);
    assign busy     = (state_q == RUN) || (state_q == DRAIN);
    assign accept   = in_valid && in_ready;
    assign clear    = start && ((state_q == IDLE) || (state_q == DONE));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = RUN;
            RUN:        if (accept && in_last) state_d = DRAIN;
            DRAIN:      if (drain_cnt == 2'(DRAIN_CYCLES - 1)) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            drain_cnt <= 2'd0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            drain_cnt <= (state_q == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
            done      <= (state_q == DRAIN) && (state_d == DONE);
        end
    end

    err_metric_unit u_metric (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   (accept),
        .a       (a),
        .b       (b),
        .approx  (prod_approx),
        .vld_p2  (vld_p2),
        .diff_p2 (diff_p2),
        .ed_p2   (ed_p2),
        .a_p2    (a_p2),
        .b_p2    (b_p2)
    );

    // Acceptance-time counting; a beat arriving at full scale is dropped and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt <= '0;
            cnt_ovf    <= 1'b0;
        end else if (clear) begin
            sample_cnt <= '0;
            cnt_ovf    <= 1'b0;
        end else if (accept) begin
            sample_cnt <= sat_inc(sample_cnt);
            if (sample_cnt == '1) cnt_ovf <= 1'b1;
        end
    end

    // Accumulation from S2 results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
            ed_sum  <= '0;
            err_sum <= '0;
            max_ed  <= '0;
            max_a   <= '0;
            max_b   <= '0;
        end else if (clear) begin
            err_cnt <= '0;
            ed_sum  <= '0;
            err_sum <= '0;
            max_ed  <= '0;
            max_a   <= '0;
            max_b   <= '0;
        end else if (vld_p2) begin
            if (ed_p2 != 16'd0) err_cnt <= err_cnt + CNT_W'(1);
            ed_sum  <= ed_sum + SUM_W'(ed_p2);
            err_sum <= err_sum + {{(SUM_W-16){diff_p2[16]}}, diff_p2};
            // Strict compare keeps the first sample on ties.
            if (ed_p2 > max_ed) begin
                max_ed <= ed_p2;
                max_a  <= a_p2;
                max_b  <= b_p2;
            end
        end
    end

`ifdef APPROX_ERR_SQ_EN
    logic [31:0] ed_sq;
    assign ed_sq = {16'b0, ed_p2} * {16'b0, ed_p2};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      sq_sum <= '0;
        else if (clear)  sq_sum <= '0;
        else if (vld_p2) sq_sum <= sq_sum + SQ_W'(ed_sq);
    end
`endif

endmodule

// File: tb/tb_approx_err_stats.sv
// Directed bench for approx_err_stats: per-cycle scoreboard from a sample-list model
// plus hand-computed expectations for each scenario.
module tb_approx_err_stats;

    localparam int CNT_W = 17;
    localparam int SUM_W = 33;

    logic clk = 0, rst_n = 1, start = 0, in_valid = 0, in_last = 0;
    logic [7:0]  a = 0, b = 0;
    logic [15:0] prod_approx = 0;
    logic        in_ready, busy, done, cnt_ovf;
    logic [CNT_W-1:0] sample_cnt, err_cnt;
    logic [SUM_W-1:0] ed_sum;
    logic [SUM_W:0]   err_sum;
    logic [15:0]      max_ed;
    logic [7:0]       max_a, max_b;
`ifdef APPROX_ERR_SQ_EN
    logic [47:0]      sq_sum;
`endif

    approx_err_stats dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_last(in_last), .a(a), .b(b),
        .prod_approx(prod_approx), .busy(busy), .done(done),
        .sample_cnt(sample_cnt), .err_cnt(err_cnt), .ed_sum(ed_sum),
        .err_sum(err_sum), .max_ed(max_ed), .max_a(max_a), .max_b(max_b),
        .cnt_ovf(cnt_ovf)
`ifdef APPROX_ERR_SQ_EN
        , .sq_sum(sq_sum)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // Model: list of accepted samples; statistics are folded two edges after acceptance.
    typedef struct {int a; int b; int p; int acc;} beat_t;
    beat_t  pend[$];
    int     cyc = 0;
    int     m_done_at = -1;
    bit     m_ready = 0;
    bit     m_ovf = 0;
    longint m_cnt = 0, m_err = 0, m_edsum = 0, m_esum = 0, m_max = 0, m_ma = 0, m_mb = 0, m_sq = 0;

    task automatic model_clear();
        m_cnt = 0; m_err = 0; m_edsum = 0; m_esum = 0;
        m_max = 0; m_ma = 0; m_mb = 0; m_sq = 0; m_ovf = 0;
        pend.delete();
    endtask

    task automatic fold(input beat_t bt);
        int d, ed;
        d  = bt.p - bt.a * bt.b;
        ed = (d < 0) ? -d : d;
        if (ed != 0) m_err++;
        m_edsum += ed;
        m_esum  += d;
        m_sq    += longint'(ed) * ed;
        if (ed > m_max) begin
            m_max = ed; m_ma = bt.a; m_mb = bt.b;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            model_clear();
            m_ready = 0;
            m_done_at = -1;
        end else begin
            cyc++;
            while (pend.size() > 0 && pend[0].acc <= cyc - 2) fold(pend.pop_front());
            if (m_ready) begin
                if (in_valid) begin
                    pend.push_back('{int'(a), int'(b), int'(prod_approx), cyc});
                    if (m_cnt == (longint'(1) << CNT_W) - 1) m_ovf = 1;
                    else m_cnt++;
                    if (in_last) begin
                        m_ready = 0;
                        m_done_at = cyc + 2;
                    end
                end
            end else if (start && (cyc - 1 >= m_done_at)) begin
                model_clear();
                m_ready = 1;
            end
        end
    end

    initial forever begin
        logic [SUM_W:0]   exp_esum;
        logic [SUM_W-1:0] exp_edsum;
        @(negedge clk);
        exp_esum  = m_esum[SUM_W:0];
        exp_edsum = m_edsum[SUM_W-1:0];
        chk("in_ready",   64'(in_ready),   64'(m_ready));
        chk("busy",       64'(busy),       64'(m_ready || (cyc < m_done_at)));
        chk("done",       64'(done),       64'(cyc == m_done_at));
        chk("sample_cnt", 64'(sample_cnt), 64'(m_cnt));
        chk("cnt_ovf",    64'(cnt_ovf),    64'(m_ovf));
        chk("err_cnt",    64'(err_cnt),    64'(m_err));
        chk("ed_sum",     64'(ed_sum),     64'(exp_edsum));
        chk("err_sum",    64'(err_sum),    64'(exp_esum));
        chk("max_ed",     64'(max_ed),     64'(m_max));
        chk("max_a",      64'(max_a),      64'(m_ma));
        chk("max_b",      64'(max_b),      64'(m_mb));
`ifdef APPROX_ERR_SQ_EN
        chk("sq_sum",     64'(sq_sum),     64'(m_sq[47:0]));
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic send(input logic [7:0] ta, input logic [7:0] tb_, input logic [15:0] tp, input logic tl);
        in_valid = 1; a = ta; b = tb_; prod_approx = tp; in_last = tl;
        tick();
        in_valid = 0; in_last = 0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (done) break;
        end
        chk("done_seen", 64'(done), 64'(1));
    endtask

    logic [SUM_W:0] neg1021, neg9;
    int lat;

    initial begin
        neg1021 = -1021;
        neg9    = -9;
        #1 rst_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        tick();
        chk("rst_sample_cnt", 64'(sample_cnt), 64'(0));
        chk("rst_in_ready",   64'(in_ready),   64'(0));

        // Exact stream
        do_start();
        send(15, 15, 225, 0);
        send(0, 200, 0, 0);
        send(255, 255, 65025, 1);
        wait_done(lat);
        chk("t1_done_latency", 64'(lat), 64'(3));
        chk("t1_sample_cnt", 64'(sample_cnt), 64'(3));
        chk("t1_err_cnt",    64'(err_cnt),    64'(0));
        chk("t1_ed_sum",     64'(ed_sum),     64'(0));
        chk("t1_err_sum",    64'(err_sum),    64'(0));
        chk("t1_max_ed",     64'(max_ed),     64'(0));
        tick();
        chk("t1_done_once",  64'(done),       64'(0));

        // Mixed error
        do_start();
        send(255, 255, 64000, 0);
        send(16, 16, 260, 1);
        wait_done(lat);
        chk("t2_err_cnt", 64'(err_cnt), 64'(2));
        chk("t2_ed_sum",  64'(ed_sum),  64'(1029));
        chk("t2_err_sum", 64'(err_sum), 64'(neg1021));
        chk("t2_max_ed",  64'(max_ed),  64'(1025));
        chk("t2_max_a",   64'(max_a),   64'(255));
        chk("t2_max_b",   64'(max_b),   64'(255));
        tick();

        // Tie on max keeps the first sample
        do_start();
        send(2, 3, 10, 0);
        send(1, 4, 0, 1);
        wait_done(lat);
        chk("t3_max_ed", 64'(max_ed), 64'(4));
        chk("t3_max_a",  64'(max_a),  64'(2));
        chk("t3_max_b",  64'(max_b),  64'(3));
        tick();

        // Handshake: valid held in DONE, bubbles in RUN, start during DRAIN
        in_valid = 1; a = 9; b = 9; prod_approx = 0;
        repeat (3) tick();
        chk("t4_done_ignores_valid", 64'(sample_cnt), 64'(2));
        start = 1;
        tick();
        start = 0;
        send(3, 5, 15, 0);
        tick();
        send(7, 7, 50, 0);
        tick();
        send(10, 10, 90, 0);
        tick();
        send(1, 1, 1, 1);
        start = 1; in_valid = 1; a = 9; b = 9; prod_approx = 0;
        tick();
        start = 0;
        wait_done(lat);
        chk("t4_sample_cnt", 64'(sample_cnt), 64'(4));
        chk("t4_err_cnt",    64'(err_cnt),    64'(2));
        chk("t4_ed_sum",     64'(ed_sum),     64'(11));
        chk("t4_err_sum",    64'(err_sum),    64'(neg9));
        chk("t4_max_ed",     64'(max_ed),     64'(10));
        chk("t4_max_a",      64'(max_a),      64'(10));
        repeat (3) tick();
        chk("t4_hold_cnt",   64'(sample_cnt), 64'(4));
        in_valid = 0;
        tick();

        // Asynchronous reset mid-run
        do_start();
        for (int i = 1; i <= 5; i++) send(8'(i), 8'(i), 16'(i * i + 1), 0);
        #2 rst_n = 0;
        #1;
        chk("t5_rst_sample_cnt", 64'(sample_cnt), 64'(0));
        chk("t5_rst_err_cnt",    64'(err_cnt),    64'(0));
        chk("t5_rst_ed_sum",     64'(ed_sum),     64'(0));
        chk("t5_rst_max_ed",     64'(max_ed),     64'(0));
        chk("t5_rst_busy",       64'(busy),       64'(0));
        chk("t5_rst_in_ready",   64'(in_ready),   64'(0));
        #3 rst_n = 1;
        tick();
        do_start();
        send(4, 4, 16, 1);
        wait_done(lat);
        chk("t5_sample_cnt", 64'(sample_cnt), 64'(1));
        tick();

        // Exhaustive run with a single error at 255*255
        do_start();
        for (int i = 0; i < 65536; i++) begin
            int av, bv;
            av = i / 256;
            bv = i % 256;
            in_valid = 1;
            a = 8'(av);
            b = 8'(bv);
            prod_approx = (av == 255 && bv == 255) ? 16'd64000 : 16'(av * bv);
            in_last = (i == 65535);
            tick();
        end
        in_valid = 0; in_last = 0;
        wait_done(lat);
        chk("t6_sample_cnt", 64'(sample_cnt), 64'(65536));
        chk("t6_cnt_ovf",    64'(cnt_ovf),    64'(0));
        chk("t6_err_cnt",    64'(err_cnt),    64'(1));
        chk("t6_max_ed",     64'(max_ed),     64'(1025));
`ifdef APPROX_ERR_SQ_EN
        chk("t6_sq_sum",     64'(sq_sum),     64'(1050625));
`endif
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/approx_err_stats.md
Name: approx_err_stats

Overview:
- Downstream error-characterisation stage for the 8x8 approximate multipliers.
- Consumes operand pairs and the approximate 16-bit product, computes the exact product internally, and accumulates error statistics over a run.
- Statistics: error count, sum of error distance (ED), signed error sum, maximum ED and the operands that caused it.
- Sits after the multiplier in the exhaustive-characterisation harness; a run is one stream of samples terminated by a last flag.

Parameters:
- CNT_W, 17, width of the sample and error counters; 17 covers 65536 samples exactly.
- SUM_W, 33, width of the ED sum; the signed sum uses SUM_W+1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; clears statistics and begins a run (honoured in IDLE/DONE only)
- in_valid  in  1  sample valid
- in_ready  out  1  high only in RUN
- in_last  in  1  final sample of the run
- a  in  8  operand A (unsigned)
- b  in  8  operand B (unsigned)
- prod_approx  in  16  approximate product under test
- busy  out  1  high in RUN or DRAIN
- done  out  1  one-cycle pulse on entry to DONE
- sample_cnt  out  CNT_W  samples accepted
- err_cnt  out  CNT_W  samples with ED != 0
- ed_sum  out  SUM_W  sum of abs(exact - approx)
- err_sum  out  SUM_W+1  signed sum of (approx - exact), two's complement
- max_ed  out  16  largest ED seen
- max_a, max_b  out  8 each  operands of the first sample reaching max_ed
- cnt_ovf  out  1  sticky; set if sample_cnt saturated

Behaviour:
- Reset state: all outputs 0, state IDLE.
- State machine:
  - IDLE/DONE --start--> RUN. Statistic registers clear in the same edge.
  - RUN --accepted beat with in_last--> DRAIN.
  - DRAIN holds 2 cycles --> DONE, and done pulses in the first DONE cycle.
  - start is ignored in RUN and DRAIN.
- Handshake:
  - Beat accepted when in_valid && in_ready.
  - in_ready is 0 in IDLE, DRAIN and DONE; in_valid there is ignored.
- Pipeline:
  - S1 registers a, b, prod_approx and exact = a*b (16-bit unsigned).
  - S2 computes diff = approx - exact (17-bit signed) and ED = abs(diff), then updates the accumulators.
  - Statistics reflect a beat 2 cycles after acceptance and are final when done pulses.
- Accumulators:
  - sample_cnt is incremented at acceptance. It saturates at all-ones and sets cnt_ovf.
  - err_cnt, ed_sum and err_sum are updated in S2. Sums wrap modulo width; defaults cannot overflow for 65536 samples.
- Max tracking:
  - Update only when ED > max_ed (strict), so ties keep the first occurrence.
  - If every ED is 0, max_ed, max_a and max_b stay 0.
- Outputs hold their values in DONE until the next start.
- Asynchronous reset mid-run clears pipeline and statistics immediately and returns to IDLE; any partial run is discarded.
- Back-to-back beats at full rate are supported; bubbles in in_valid do not advance S2 accumulation (valid bit travels with the pipeline).

Optional Feature:
- Macro: APPROX_ERR_SQ_EN.
- Defined:
  - Adds output sq_sum (48 bits), the sum of ED*ED computed in S2, for MSE.
  - Cleared by start and reset. Latency is unchanged.
- Undefined: port and multiplier absent.

Decomposition:
- Shared package approx_stats_pkg holds:
  - Parameter defaults CNT_W and SUM_W.
  - State enum (IDLE, RUN, DRAIN, DONE).
  - Localparams DRAIN_CYCLES = 2 and SQ_W = 48.
- One natural sub-module, err_metric_unit: the S1/S2 datapath, which takes a, b, approx and valid and produces the registered diff, ED and valid.
- The FSM and accumulators stay in the top level.

Test Plan:
- Exact stream: start; 3 beats (15,15,225), (0,200,0), (255,255,65025) with last on the third -> sample_cnt=3, err_cnt=0, ed_sum=0, err_sum=0, max_ed=0; done pulses once, 3 cycles after the last beat.
- Mixed error: beats (255,255,64000), (16,16,260) last -> err_cnt=2, ed_sum=1029, err_sum=-1021, max_ed=1025, max_a=255, max_b=255.
- Tie on max: beats (2,3,10) then (1,4,0) last -> max_ed=4 with max_a=2, max_b=3 retained.
- Handshake: in_valid toggled 1/0 every cycle over 4 beats, and in_valid held high in IDLE and DONE -> only the 4 RUN beats counted; in_ready=0 outside RUN; start during DRAIN has no effect.
- Reset mid-run: assert rst_n=0 after 5 beats -> all outputs 0 asynchronously and state IDLE; a new start and 1 beat give sample_cnt=1.
- Full exhaustive run of 65536 beats, with prod_approx=exact except a=b=255 -> sample_cnt=65536, cnt_ovf=0, err_cnt=1. With APPROX_ERR_SQ_EN and an ED of 1025 on that beat -> sq_sum=1050625.
